// File: rtl/shake_pkg.sv
// Shared definitions for the SHAKE/SHA3 absorb front-end: mode encodings,
// rate lookup, domain-separation constants and the packer FSM states.
package shake_pkg;

  typedef enum logic [1:0] {
    MODE_SHA3_256 = 2'b00,
    MODE_SHA3_512 = 2'b01,
    MODE_SHAKE128 = 2'b10,
    MODE_SHAKE256 = 2'b11
  } mode_e;

  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_EMIT,
    ST_PAD,
    ST_EMIT_LAST,
    ST_FIN
  } state_e;

  function automatic logic [7:0] rate_bytes(input mode_e mode);
    case (mode)
      MODE_SHA3_256: rate_bytes = 8'd136;
      MODE_SHA3_512: rate_bytes = 8'd72;
      MODE_SHAKE128: rate_bytes = 8'd168;
      default:       rate_bytes = 8'd136;
    endcase
  endfunction

  function automatic logic [7:0] domain_byte(input mode_e mode);
    case (mode)
      MODE_SHAKE128, MODE_SHAKE256: domain_byte = DOM_SHAKE;
      default:                      domain_byte = DOM_SHA3;
    endcase
  endfunction

endpackage

// File: rtl/shake_absorb_packer_if.sv
// Stream-in / block-out signal bundle of the absorb packer.
// slave is the packer's view, master is the surrounding DMA/Keccak view.
interface shake_absorb_packer_if #(
  parameter int DATA_W   = 64,
  parameter int RATE_MAX = 1344
);
  logic                s_tvalid;
  logic                s_tready;
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tlast;
  logic [RATE_MAX-1:0] block_data;
  logic                block_valid;
  logic                block_ready;
  logic                block_last;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, block_ready,
    output s_tready, block_data, block_valid, block_last
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, block_ready,
    input  s_tready, block_data, block_valid, block_last
  );
endinterface

// File: rtl/shake_block_buffer.sv
// Rate-sized absorb block register with a byte-offset beat write port,
// a single-byte XOR port for padding, and a synchronous clear.
module shake_block_buffer #(
  parameter int DATA_W   = 64,
  parameter int RATE_MAX = 1344,
  parameter int CNT_W    = $clog2(DATA_W / 8 + 1)
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [7:0]          wr_off,
  input  logic [CNT_W-1:0]    wr_cnt,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                xor_en,
  input  logic [7:0]          xor_off,
  input  logic [7:0]          xor_byte,
  output logic [RATE_MAX-1:0] data
);

  localparam int NB  = RATE_MAX / 8;
  localparam int BPB = DATA_W / 8;

  logic [RATE_MAX-1:0] blk_q;
  logic [RATE_MAX-1:0] blk_d;

  // Lane j of the beat lands on byte wr_off+j; lanes at or beyond wr_cnt are dropped.
  always_comb begin
    blk_d = blk_q;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < BPB; j++) begin
        if (wr_en && (j < int'(wr_cnt)) && (int'(wr_off) + j == i))
          blk_d[8*i +: 8] = wr_data[8*j +: 8];
      end
      if (xor_en && (int'(xor_off) == i))
        blk_d[8*i +: 8] = blk_d[8*i +: 8] ^ xor_byte;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      blk_q <= '0;
    else if (clr)
      blk_q <= '0;
    else
      blk_q <= blk_d;
  end

  assign data = blk_q;

endmodule

// File: rtl/shake_absorb_packer.sv
// Absorb front-end for the Keccak core: packs a byte stream into rate-sized
// blocks and appends FIPS-202 domain separation plus pad10*1.
module shake_absorb_packer
  import shake_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [31:0]          msg_len,
  shake_absorb_packer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 length_err
);

  localparam int BPB   = DATA_W / 8;
  localparam int CNT_W = $clog2(BPB + 1);

  state_e      state_q, state_d;
  mode_e       mode_q;
  logic [31:0] len_q;
  logic [31:0] rcv_q;
  logic [7:0]  fill_q;
  logic        ended_q;
  logic        len_err_q;

  logic [7:0]       rate;
  logic [7:0]       dom;
  logic [31:0]      remain;
  logic [CNT_W-1:0] take;
  logic [7:0]       fill_nxt;
  logic [31:0]      rcv_nxt;
  logic             early_last;
  logic             msg_end;
  logic             beat_hs;

  logic                buf_clr;
  logic                wr_en;
  logic [7:0]          wr_off;
  logic [CNT_W-1:0]    wr_cnt;
  logic [DATA_W-1:0]   wr_data;
  logic                xor_en;
  logic [7:0]          xor_off;
  logic [7:0]          xor_byte;
  logic [RATE_MAX-1:0] blk_data;

  logic s_tready;
  logic block_valid;
  logic block_last;

  assign rate = rate_bytes(mode_q);
  assign dom  = domain_byte(mode_q);

  // The final beat of a message only contributes its remaining bytes.
  always_comb begin
    remain     = len_q - rcv_q;
    take       = (remain < 32'(BPB)) ? remain[CNT_W-1:0] : CNT_W'(BPB);
    fill_nxt   = fill_q + 8'(take);
    rcv_nxt    = rcv_q + 32'(take);
    early_last = bus.s_tlast && (rcv_nxt < len_q);
    msg_end    = (rcv_nxt == len_q) || early_last;
    beat_hs    = (state_q == ST_FILL) && bus.s_tvalid;
  end

  always_comb begin
    state_d     = state_q;
    s_tready    = 1'b0;
    block_valid = 1'b0;
    block_last  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    buf_clr     = 1'b0;
    wr_en       = 1'b0;
    wr_off      = fill_q;
    wr_cnt      = take;
    wr_data     = bus.s_tdata;
    xor_en      = 1'b0;
    xor_off     = fill_q;
    xor_byte    = dom;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_clr = 1'b1;
          state_d = (msg_len == 32'd0) ? ST_PAD : ST_FILL;
        end
      end
      ST_FILL: begin
        busy     = 1'b1;
        s_tready = 1'b1;
        if (bus.s_tvalid) begin
          wr_en = 1'b1;
          if (fill_nxt == rate)
            state_d = ST_EMIT;
          else if (msg_end)
            state_d = ST_PAD;
        end
      end
      ST_EMIT: begin
        busy        = 1'b1;
        block_valid = 1'b1;
        if (bus.block_ready) begin
          buf_clr = 1'b1;
          state_d = ended_q ? ST_PAD : ST_FILL;
        end
      end
      ST_PAD: begin
        // Bytes past fill_q are still zero, so the end marker can be written
        // outright unless it shares a byte with the domain suffix.
        busy   = 1'b1;
        xor_en = 1'b1;
        if (fill_q == rate - 8'd1) begin
          xor_byte = dom ^ PAD_END;
        end else begin
          wr_en   = 1'b1;
          wr_off  = rate - 8'd1;
          wr_cnt  = CNT_W'(1);
          wr_data = {{(DATA_W-8){1'b0}}, PAD_END};
        end
        state_d = ST_EMIT_LAST;
      end
      ST_EMIT_LAST: begin
        busy        = 1'b1;
        block_valid = 1'b1;
        block_last  = 1'b1;
        if (bus.block_ready)
          state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SHA3_256;
      len_q     <= '0;
      rcv_q     <= '0;
      fill_q    <= '0;
      ended_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode_e'(mode);
            len_q     <= msg_len;
            rcv_q     <= '0;
            fill_q    <= '0;
            ended_q   <= 1'b0;
            len_err_q <= 1'b0;
          end
        end
        ST_FILL: begin
          if (beat_hs) begin
            fill_q <= fill_nxt;
            rcv_q  <= rcv_nxt;
            if (msg_end)
              ended_q <= 1'b1;
            if (early_last)
              len_err_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.block_ready)
            fill_q <= '0;
        end
        default: ;
      endcase
    end
  end

  shake_block_buffer #(
    .DATA_W  (DATA_W),
    .RATE_MAX(RATE_MAX),
    .CNT_W   (CNT_W)
  ) u_buf (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (buf_clr),
    .wr_en   (wr_en),
    .wr_off  (wr_off),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .xor_en  (xor_en),
    .xor_off (xor_off),
    .xor_byte(xor_byte),
    .data    (blk_data)
  );

  assign bus.s_tready    = s_tready;
  assign bus.block_valid = block_valid;
  assign bus.block_last  = block_last;
  assign bus.block_data  = blk_data;
  assign length_err      = len_err_q;

endmodule
